// File: rtl/tlp_request_engine.sv
// tlp_request_engine: accepts request TLPs one DW per beat, decodes MEM / IO / CFG requests
// (3DW or 4DW header), waits a fixed completer latency for well-formed requests, then streams a
// completion of one or more DWs with a status code.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   in_data/valid/ready request stream (header DWs then payload DWs)
//   out_data/valid/last completion stream, out_last marks the final beat of a request
//   next_ready          downstream ready for the completion stream
//   completion_status   1000 success, 1001 unsupported request, 1010 malformed (valid with out_valid)
//   busy                high whenever the engine is not idle
module tlp_request_engine #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DELAY       = 25,
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter int unsigned DCNT_W      = $clog2(DELAY + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              next_ready,
  output logic [3:0]        completion_status,
  output logic              busy
);

  localparam logic [10:0]       MaxLen  = 11'(MAX_PAYLOAD);
  localparam logic [DCNT_W-1:0] DelayLd = DCNT_W'(DELAY);

  typedef enum logic [2:0] {StIdle, StHdr, StPay, StWait, StResp} state_e;
  typedef enum logic [1:0] {KindMem, KindIoCfg, KindUr, KindMal} kind_e;

  state_e             state_q, state_d;
  kind_e              kind_q, kind_d;
  logic               has_data_q, has_data_d;
  logic               four_dw_q, four_dw_d;
  logic [10:0]        len_q, len_d;
  logic [1:0]         idx_q, idx_d;   // index of the next header DW
  logic [10:0]        cnt_q, cnt_d;   // payload beat count in PAY, completion beat in RESP
  logic [31:0]        win_q, win_d;   // addr[47:16], the only address bits a completion uses
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic               live_q, live_d; // completion presented from the second RESP cycle on

  // DW0 decode
  logic [10:0] len_dec;
  kind_e       kind_dec;

  assign len_dec = (in_data[9:0] == 10'd0) ? 11'd1024 : {1'b0, in_data[9:0]};

  always_comb begin
    case (in_data[28:24])
      5'b00000:                     kind_dec = (len_dec > MaxLen) ? KindMal : KindMem;
      5'b00010, 5'b00100, 5'b00101: kind_dec = (in_data[29] || len_dec != 11'd1) ? KindMal
                                                                                  : KindIoCfg;
      default:                      kind_dec = KindUr;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      kind_q     <= KindMem;
      has_data_q <= 1'b0;
      four_dw_q  <= 1'b0;
      len_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      win_q      <= '0;
      dcnt_q     <= '0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      has_data_q <= has_data_d;
      four_dw_q  <= four_dw_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      dcnt_q     <= dcnt_d;
      live_q     <= live_d;
    end
  end

  logic   good;
  state_e end_state;

  always_comb begin
    state_d           = state_q;
    kind_d            = kind_q;
    has_data_d        = has_data_q;
    four_dw_d         = four_dw_q;
    len_d             = len_q;
    idx_d             = idx_q;
    cnt_d             = cnt_q;
    win_d             = win_q;
    dcnt_d            = dcnt_q;
    live_d            = live_q;
    in_ready          = 1'b0;
    out_valid         = 1'b0;
    out_data          = '0;
    out_last          = 1'b0;
    completion_status = 4'd0;
    good              = (kind_q == KindMem) || (kind_q == KindIoCfg);
    // Bad requests go straight to RESP; its staging cycle gives the one-edge response latency.
    end_state         = good ? StWait : StResp;

    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          kind_d     = kind_dec;
          has_data_d = in_data[30];
          four_dw_d  = in_data[29];
          len_d      = len_dec;
          idx_d      = 2'd1;
          win_d      = '0;
          cnt_d      = '0;
          state_d    = StHdr;
        end
      end
      StHdr: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (idx_q == 2'd2) begin
            // 4DW: DW2 is addr[63:32]; 3DW: DW2 is addr[31:0] with an all-zero upper half
            win_d = four_dw_q ? {in_data[15:0], 16'h0000} : {16'h0000, in_data[31:16]};
          end
          if (idx_q == 2'd3) begin
            win_d[15:0] = in_data[31:16];
          end
          idx_d = idx_q + 2'd1;
          if (idx_q == {1'b1, four_dw_q}) begin
            if (has_data_q) begin
              state_d = StPay;
            end else begin
              state_d = end_state;
              dcnt_d  = DelayLd;
            end
          end
        end
      end
      StPay: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d = cnt_q + 11'd1;
          if (cnt_q == len_q - 11'd1) begin
            cnt_d   = '0;
            state_d = end_state;
            dcnt_d  = DelayLd;
          end
        end
      end
      StWait: begin
        dcnt_d = dcnt_q - DCNT_W'(1);
        if (dcnt_q == DCNT_W'(1)) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (!live_q) begin
          live_d = 1'b1;
        end else begin
          out_valid = 1'b1;
          unique case (kind_q)
            KindMem: begin
              completion_status = 4'b1000;
              if (has_data_q) begin
                out_last = 1'b1;
              end else begin
                out_data = ~win_q + {21'd0, cnt_q};
                out_last = (cnt_q == len_q - 11'd1);
              end
            end
            KindIoCfg: begin
              completion_status = 4'b1000;
              out_last          = 1'b1;
              out_data          = has_data_q ? '0 : ~win_q;
            end
            KindUr: begin
              completion_status = 4'b1001;
              out_last          = 1'b1;
            end
            KindMal: begin
              completion_status = 4'b1010;
              out_last          = 1'b1;
            end
          endcase
          if (next_ready) begin
            if (out_last) begin
              state_d = StIdle;
              live_d  = 1'b0;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 11'd1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_tlp_request_engine.sv
module tb_tlp_request_engine;

  localparam int DELAY = 25;
  localparam int MAXP  = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        next_ready = 1'b0;
  logic [3:0]  completion_status;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  tlp_request_engine #(
    .DATA_W      (32),
    .DELAY       (DELAY),
    .MAX_PAYLOAD (MAXP)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_last          (out_last),
    .next_ready        (next_ready),
    .completion_status (completion_status),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat with random idle gaps; returns just after the accepting edge.
  task automatic put_beat(input logic [31:0] d);
    int guard;
    bit done;
    guard = 0;
    done  = 0;
    while (!done) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = in_valid ? d : $urandom;
      done     = in_valid && in_ready;
      step();
      guard++;
      if (!done && guard > 64) begin
        $display("FAIL in_ready_timeout: got 0 expected 1");
        $fatal(1, "input stalled");
      end
    end
    in_valid = 1'b0;
  endtask

  // Reference model: expected completion derived from the request rules, then drive and compare.
  task automatic run_req(input logic [31:0] dw0, input logic [63:0] addr_in, input int stall_beat);
    logic [63:0] a;
    logic [31:0] base;
    logic [31:0] exp_d[$];
    logic [3:0]  st;
    logic [4:0]  typ;
    bit          four, wr;
    int          len, npay, lat, n, stall;
    four = dw0[29];
    wr   = dw0[30];
    typ  = dw0[28:24];
    len  = (dw0[9:0] == 10'd0) ? 1024 : int'(dw0[9:0]);
    a    = four ? addr_in : {32'h0, addr_in[31:0]};
    base = ~a[47:16];
    if (typ == 5'd0)                               st = (len > MAXP) ? 4'b1010 : 4'b1000;
    else if (typ == 5'd2 || typ == 5'd4 || typ == 5'd5) st = (four || len != 1) ? 4'b1010 : 4'b1000;
    else                                           st = 4'b1001;
    npay = wr ? len : 0;
    exp_d = {};
    if (st != 4'b1000 || wr) exp_d.push_back(32'h0);
    else if (typ == 5'd0) for (int i = 0; i < len; i++) exp_d.push_back(base + 32'(i));
    else exp_d.push_back(base);
    lat = (st == 4'b1000) ? DELAY + 1 : 1;

    put_beat(dw0);
    put_beat($urandom);
    if (four) begin
      put_beat(addr_in[63:32]);
      put_beat(addr_in[31:0]);
    end else begin
      put_beat(addr_in[31:0]);
    end
    for (int i = 0; i < npay; i++) put_beat((i == npay / 2) ? 32'h0 : $urandom);

    // Junk offered while in_ready is low must be ignored.
    n = 0;
    in_valid = 1'b1;
    in_data  = $urandom;
    while (!out_valid && n < lat + 20) begin
      step();
      n++;
    end
    in_valid = 1'b0;
    check("latency", n, lat);
    if (!out_valid) return;

    for (int i = 0; i < exp_d.size(); i++) begin
      stall = (i == stall_beat) ? 5 : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      for (int s = 0; s < stall; s++) begin
        next_ready = 1'b0;
        check("hold_data", out_data, exp_d[i]);
        check("hold_last", out_last, (i == exp_d.size() - 1));
        step();
      end
      next_ready = 1'b1;
      check("valid", out_valid, 1);
      check("data", out_data, exp_d[i]);
      check("status", completion_status, st);
      check("last", out_last, (i == exp_d.size() - 1));
      check("in_ready_resp", in_ready, 0);
      step();
      next_ready = 1'b0;
    end
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_status"}, completion_status, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    bit          seen;
    logic [2:0]  f;
    logic [4:0]  t;
    int          l;

    repeat (3) step();
    check_idle_outputs("reset");
    reset = 1'b1;
    step();
    check_idle_outputs("post_reset");

    run_req(32'h0000_0004, 64'h0000_0000_89AB_CDEF, -1);
    run_req(32'h6000_0002, 64'h0000_1234_5678_0000, -1);
    run_req(32'h0000_0004, 64'h0000_0000_89AB_CDEF, 1);
    run_req(32'h4000_0064, 64'h0, -1);
    run_req(32'h1F00_0001, 64'h0000_0000_1111_2222, -1);
    run_req(32'h0000_0002, 64'h0000_0000_0000_0000, -1);
    run_req(32'h0000_0040, 64'h0000_0000_0001_0000, -1);
    run_req(32'h0000_0000, 64'h0000_0000_1234_5678, -1);

    // Reset during WAIT aborts the request.
    put_beat(32'h0000_0004);
    put_beat(32'h0);
    put_beat(32'h89AB_CDEF);
    repeat (10) step();
    check("wait_busy", busy, 1);
    reset = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    step();
    reset = 1'b1;
    step();
    check_idle_outputs("after_reset");
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) seen = 1;
      step();
    end
    check("no_stale", seen, 0);

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 7))
        0: begin f = 3'b000; t = 5'd0; l = $urandom_range(1, 8); end
        1: begin f = 3'b001; t = 5'd0; l = $urandom_range(1, 8); end
        2: begin f = {2'b01, 1'($urandom_range(0, 1))}; t = 5'd0; l = $urandom_range(1, 6); end
        3: begin f = {1'b0, 1'($urandom_range(0, 1)), 1'b0}; t = 5'd2; l = 1; end
        4: begin
          f = {1'b0, 1'($urandom_range(0, 1)), 1'b0};
          t = ($urandom_range(0, 1) != 0) ? 5'd4 : 5'd5;
          l = 1;
        end
        5: begin
          t = 5'($urandom_range(0, 31));
          while (t == 5'd0 || t == 5'd2 || t == 5'd4 || t == 5'd5) t = 5'($urandom_range(0, 31));
          f = {1'b0, 2'($urandom_range(0, 3))};
          l = $urandom_range(1, 4);
        end
        6: begin
          if ($urandom_range(0, 1) != 0) begin
            f = {1'b0, 1'($urandom_range(0, 1)), 1'b1};
            t = 5'd2;
            l = 1;
          end else begin
            f = 3'b000;
            t = 5'd4;
            l = $urandom_range(2, 3);
          end
        end
        default: begin f = 3'b000; t = 5'd0; l = ($urandom_range(0, 1) != 0) ? 64 : 65; end
      endcase
      run_req({f, t, 14'($urandom), 10'(l)}, {$urandom, $urandom}, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
